// File: rtl/mips32_mc_sequencer.sv
// Multicycle control sequencer: steps each MIPS32 instruction through
// fetch/decode/execute/memory/write-back over a shared, ready-handshaked memory port.
module mips32_mc_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opc,
  input  logic [5:0]  func,
  input  logic        memReady,
  input  logic        aluZero,
  output logic        memReq,
  output logic        memWe,
  output logic        iOrD,
  output logic        irWrite,
  output logic        pcWrite,
  output logic [1:0]  pcSrc,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [2:0]  aluFunc,
  output logic        rfWriteEnable,
  output logic        rfWriteAddrSel,
  output logic        rfWriteDataSel,
  output logic        instrDone,
  output logic [31:0] instrCount,
  output logic        invOpcode,
  output logic        busErr,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_WB_ALU = 3'd5,
    S_WB_MEM = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Last tolerated wait count: the access errors when the count would reach MEM_TIMEOUT.
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] count_q;
  logic        inv_q, inv_d;
  logic        bus_q, bus_d;

  logic        is_r_s, is_beq_s, is_bne_s, is_lw_s, is_sw_s, is_j_s, timeout_s;
  logic        mem_req_s, mem_we_s, iord_s, ir_wr_s, pc_wr_s;
  logic [1:0]  pc_src_s, src_b_s;
  logic        src_a_s, rf_we_s, rf_as_s, rf_ds_s, done_s;
  logic [2:0]  alu_fn_s, r_fn_s;

  // Instruction class decode from the held IR fields.
  always_comb begin
    is_r_s   = 1'b0;
    r_fn_s   = ALU_ADD;
    if (opc == OP_RTYPE) begin
      case (func)
        FN_ADD:  begin is_r_s = 1'b1; r_fn_s = ALU_ADD; end
        FN_SUB:  begin is_r_s = 1'b1; r_fn_s = ALU_SUB; end
        FN_AND:  begin is_r_s = 1'b1; r_fn_s = ALU_AND; end
        FN_OR:   begin is_r_s = 1'b1; r_fn_s = ALU_OR;  end
        FN_SLT:  begin is_r_s = 1'b1; r_fn_s = ALU_SLT; end
        default: begin is_r_s = 1'b0; r_fn_s = ALU_ADD; end
      endcase
    end else begin
      is_r_s = 1'b0;
      r_fn_s = ALU_ADD;
    end
    is_beq_s  = (opc == OP_BEQ);
    is_bne_s  = (opc == OP_BNE);
    is_lw_s   = (opc == OP_LW);
    is_sw_s   = (opc == OP_SW);
    is_j_s    = (opc == OP_J);
    timeout_s = (wait_q == WAIT_LIMIT) && !memReady;
  end

  // Next-state, sticky halt causes and per-state control outputs.
  always_comb begin
    state_d   = state_q;
    inv_d     = inv_q;
    bus_d     = bus_q;
    mem_req_s = 1'b0;
    mem_we_s  = 1'b0;
    iord_s    = 1'b0;
    ir_wr_s   = 1'b0;
    pc_wr_s   = 1'b0;
    pc_src_s  = 2'd0;
    src_a_s   = 1'b0;
    src_b_s   = 2'd0;
    alu_fn_s  = 3'd0;
    rf_we_s   = 1'b0;
    rf_as_s   = 1'b0;
    rf_ds_s   = 1'b0;
    done_s    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_s = 1'b1;
        src_b_s   = 2'd1;
        alu_fn_s  = ALU_ADD;
        if (memReady) begin
          ir_wr_s = 1'b1;
          pc_wr_s = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_s) begin
          bus_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        src_b_s  = 2'd3;
        alu_fn_s = ALU_ADD;
        if (is_r_s || is_lw_s || is_sw_s || is_beq_s || is_bne_s) begin
          state_d = S_EXEC;
        end else if (is_j_s) begin
          pc_wr_s  = 1'b1;
          pc_src_s = 2'd2;
          done_s   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          inv_d   = 1'b1;
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        src_a_s = 1'b1;
        if (is_r_s) begin
          alu_fn_s = r_fn_s;
          state_d  = S_WB_ALU;
        end else if (is_lw_s || is_sw_s) begin
          src_b_s  = 2'd2;
          alu_fn_s = ALU_ADD;
          state_d  = is_lw_s ? S_MEM_RD : S_MEM_WR;
        end else if (is_beq_s || is_bne_s) begin
          alu_fn_s = ALU_SUB;
          pc_src_s = 2'd1;
          pc_wr_s  = (is_beq_s && aluZero) || (is_bne_s && !aluZero);
          done_s   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          // IR changed under us; treat as an illegal instruction rather than guess.
          inv_d   = 1'b1;
          state_d = S_HALT;
        end
      end
      S_MEM_RD: begin
        mem_req_s = 1'b1;
        iord_s    = 1'b1;
        if (memReady) begin
          state_d = S_WB_MEM;
        end else if (timeout_s) begin
          bus_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_MEM_WR: begin
        mem_req_s = 1'b1;
        mem_we_s  = 1'b1;
        iord_s    = 1'b1;
        if (memReady) begin
          done_s  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout_s) begin
          bus_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          state_d = S_MEM_WR;
        end
      end
      S_WB_ALU: begin
        rf_we_s = 1'b1;
        rf_as_s = 1'b1;
        done_s  = 1'b1;
        state_d = S_FETCH;
      end
      S_WB_MEM: begin
        rf_we_s = 1'b1;
        rf_ds_s = 1'b1;
        done_s  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // Wait counter restarts on every state change, counts stalled memory cycles otherwise.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if ((state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR) && !memReady) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  // Sequencer state, wait counter, sticky flags and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= 8'd0;
      count_q <= 32'd0;
      inv_q   <= 1'b0;
      bus_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_q + {31'd0, done_s};
      inv_q   <= inv_d;
      bus_q   <= bus_d;
    end
  end

  // Controls are gated by rst_n so nothing leaks out while reset is held.
  assign memReq         = rst_n & mem_req_s;
  assign memWe          = rst_n & mem_we_s;
  assign iOrD           = rst_n & iord_s;
  assign irWrite        = rst_n & ir_wr_s;
  assign pcWrite        = rst_n & pc_wr_s;
  assign pcSrc          = rst_n ? pc_src_s : 2'd0;
  assign aluSrcA        = rst_n & src_a_s;
  assign aluSrcB        = rst_n ? src_b_s : 2'd0;
  assign aluFunc        = rst_n ? alu_fn_s : 3'd0;
  assign rfWriteEnable  = rst_n & rf_we_s;
  assign rfWriteAddrSel = rst_n & rf_as_s;
  assign rfWriteDataSel = rst_n & rf_ds_s;
  assign instrDone      = rst_n & done_s;
  assign instrCount     = count_q;
  assign invOpcode      = inv_q;
  assign busErr         = bus_q;
  assign state          = state_q;

endmodule
